// File: rtl/pit_pkg.sv
// Shared definitions for the point-in-triangle pipeline: FSM states, widths, latency.
package pit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    READY = 2'd2
  } pit_state_e;

  localparam int PIT_LATENCY = 3;

  function automatic int DELTA_W(input int coord_w);
    return coord_w + 1;
  endfunction

  function automatic int EDGE_W(input int coord_w);
    return 2 * coord_w + 3;
  endfunction

endpackage

// File: rtl/pit_edge_fn.sv
// Signed edge function e = (v1-v0) x (p-v0). The caller supplies the offset (p-v0),
// so the same block serves both the per-point edges and the triangle area.
module pit_edge_fn
  import pit_pkg::*;
#(
  parameter int COORD_W = 11
) (
  input  logic        [COORD_W-1:0]          v0x_i,
  input  logic        [COORD_W-1:0]          v0y_i,
  input  logic        [COORD_W-1:0]          v1x_i,
  input  logic        [COORD_W-1:0]          v1y_i,
  input  logic signed [DELTA_W(COORD_W)-1:0] dx_i,
  input  logic signed [DELTA_W(COORD_W)-1:0] dy_i,
  output logic signed [EDGE_W(COORD_W)-1:0]  e_o
);

  localparam int DW = DELTA_W(COORD_W);
  localparam int PW = 2 * COORD_W + 2;

  logic signed [DW-1:0] ex_s;
  logic signed [DW-1:0] ey_s;
  logic signed [PW-1:0] m0_s;
  logic signed [PW-1:0] m1_s;

  assign ex_s = {1'b0, v1x_i} - {1'b0, v0x_i};
  assign ey_s = {1'b0, v1y_i} - {1'b0, v0y_i};

  // Operands are sign-extended to the product width; the low PW bits are the exact product.
  assign m0_s = {{(PW-DW){ex_s[DW-1]}}, ex_s} * {{(PW-DW){dy_i[DW-1]}}, dy_i};
  assign m1_s = {{(PW-DW){ey_s[DW-1]}}, ey_s} * {{(PW-DW){dx_i[DW-1]}}, dx_i};

  assign e_o = {m0_s[PW-1], m0_s} - {m1_s[PW-1], m1_s};

endmodule

// File: rtl/point_in_triangle_pipe.sv
// Pipelined point-in-triangle tester: latch a triangle, then classify one point per
// cycle with a three-register pipeline and valid/ready flow control on both sides.
module point_in_triangle_pipe
  import pit_pkg::*;
#(
  parameter int COORD_W   = 11,
  parameter bit INCLUSIVE = 1'b1
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               tri_load,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic               tri_ready,
  output logic               tri_degenerate,
  input  logic               p_valid,
  output logic               p_ready,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               q_valid,
  input  logic               q_ready,
  output logic               q_inside,
  output logic [COORD_W-1:0] q_px,
  output logic [COORD_W-1:0] q_py
);

  localparam int DW = DELTA_W(COORD_W);
  localparam int EW = EDGE_W(COORD_W);

  pit_state_e state_q, state_d;

  logic [COORD_W-1:0] vx_q [3];
  logic [COORD_W-1:0] vy_q [3];
  logic area_pos_q, degen_q;

  logic                s1_valid_q;
  logic [COORD_W-1:0]  s1_px_q, s1_py_q;
  logic signed [DW-1:0] s1_dx_q [3];
  logic signed [DW-1:0] s1_dy_q [3];

  logic               s2_valid_q;
  logic [COORD_W-1:0] s2_px_q, s2_py_q;
  logic [2:0]         s2_neg_q, s2_pos_q;

  logic               q_valid_q, q_inside_q;
  logic [COORD_W-1:0] q_px_q, q_py_q;

  logic tri_ready_s, p_ready_s, in_setup_s, inside_s;
  logic stall_s, busy_s, tri_take_s, accept_s;
  logic signed [EW-1:0] edge_s [3];
  logic signed [EW-1:0] area_s;
  logic signed [DW-1:0] area_dx_s, area_dy_s;
  logic [2:0] e_neg_s, e_pos_s;

  assign stall_s    = q_valid_q && !q_ready;
  assign busy_s     = s1_valid_q || s2_valid_q || q_valid_q;
  assign tri_take_s = tri_load && tri_ready_s;
  assign accept_s   = p_valid && p_ready_s;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tri_take_s) state_d = SETUP; else state_d = IDLE;
      SETUP:   state_d = READY;
      READY:   if (tri_take_s) state_d = SETUP; else state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  // A new triangle is only taken once the pipeline is empty, so in-flight points keep theirs.
  always_comb begin
    tri_ready_s = 1'b0;
    p_ready_s   = 1'b0;
    in_setup_s  = 1'b0;
    case (state_q)
      IDLE:  tri_ready_s = !busy_s;
      SETUP: in_setup_s  = 1'b1;
      READY: begin
        tri_ready_s = !busy_s;
        p_ready_s   = !tri_load && !stall_s;
      end
      default: tri_ready_s = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= {COORD_W{1'b0}};
        vy_q[i] <= {COORD_W{1'b0}};
      end
    end else if (tri_take_s) begin
      vx_q[0] <= ax;  vy_q[0] <= ay;
      vx_q[1] <= bx;  vy_q[1] <= by;
      vx_q[2] <= cx;  vy_q[2] <= cy;
    end
  end

  // Twice the signed area is the edge function of a->b evaluated at c.
  assign area_dx_s = {1'b0, vx_q[2]} - {1'b0, vx_q[0]};
  assign area_dy_s = {1'b0, vy_q[2]} - {1'b0, vy_q[0]};

  pit_edge_fn #(.COORD_W(COORD_W)) u_area (
    .v0x_i(vx_q[0]), .v0y_i(vy_q[0]), .v1x_i(vx_q[1]), .v1y_i(vy_q[1]),
    .dx_i(area_dx_s), .dy_i(area_dy_s), .e_o(area_s)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      area_pos_q <= 1'b0;
      degen_q    <= 1'b0;
    end else if (in_setup_s) begin
      area_pos_q <= !area_s[EW-1] && (|area_s);
      degen_q    <= ~|area_s;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_edge
    localparam int J = (i + 1) % 3;
    pit_edge_fn #(.COORD_W(COORD_W)) u_edge (
      .v0x_i(vx_q[i]), .v0y_i(vy_q[i]), .v1x_i(vx_q[J]), .v1y_i(vy_q[J]),
      .dx_i(s1_dx_q[i]), .dy_i(s1_dy_q[i]), .e_o(edge_s[i])
    );
    assign e_neg_s[i] = edge_s[i][EW-1];
    assign e_pos_s[i] = !edge_s[i][EW-1] && (|edge_s[i]);
  end

  // Winding is normalised by the area sign: all edges must agree with it.
  always_comb begin
    inside_s = 1'b0;
    if (degen_q)         inside_s = 1'b0;
    else if (area_pos_q) inside_s = INCLUSIVE ? (&(~s2_neg_q)) : (&s2_pos_q);
    else                 inside_s = INCLUSIVE ? (&(~s2_pos_q)) : (&s2_neg_q);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid_q <= 1'b0;
      s1_px_q    <= {COORD_W{1'b0}};
      s1_py_q    <= {COORD_W{1'b0}};
      for (int i = 0; i < 3; i++) begin
        s1_dx_q[i] <= {DW{1'b0}};
        s1_dy_q[i] <= {DW{1'b0}};
      end
      s2_valid_q <= 1'b0;
      s2_px_q    <= {COORD_W{1'b0}};
      s2_py_q    <= {COORD_W{1'b0}};
      s2_neg_q   <= 3'b000;
      s2_pos_q   <= 3'b000;
      q_valid_q  <= 1'b0;
      q_inside_q <= 1'b0;
      q_px_q     <= {COORD_W{1'b0}};
      q_py_q     <= {COORD_W{1'b0}};
    end else if (!stall_s) begin
      s1_valid_q <= accept_s;
      if (accept_s) begin
        s1_px_q <= px;
        s1_py_q <= py;
        for (int i = 0; i < 3; i++) begin
          s1_dx_q[i] <= {1'b0, px} - {1'b0, vx_q[i]};
          s1_dy_q[i] <= {1'b0, py} - {1'b0, vy_q[i]};
        end
      end
      s2_valid_q <= s1_valid_q;
      s2_px_q    <= s1_px_q;
      s2_py_q    <= s1_py_q;
      s2_neg_q   <= e_neg_s;
      s2_pos_q   <= e_pos_s;
      q_valid_q  <= s2_valid_q;
      q_inside_q <= inside_s;
      q_px_q     <= s2_px_q;
      q_py_q     <= s2_py_q;
    end
  end

  assign tri_ready      = tri_ready_s;
  assign p_ready        = p_ready_s;
  assign tri_degenerate = degen_q;
  assign q_valid        = q_valid_q;
  assign q_inside       = q_inside_q;
  assign q_px           = q_px_q;
  assign q_py           = q_py_q;

endmodule

// File: tb/tb_point_in_triangle_pipe.sv
// Scoreboard bench: two instances (inclusive and exclusive edges) share all inputs;
// the driver queues expected results, a monitor pops and compares them.
module tb_point_in_triangle_pipe;

  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tri_load = 1'b0;
  logic [CW-1:0] ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
  logic p_valid = 1'b0;
  logic [CW-1:0] px = '0, py = '0;
  logic q_ready = 1'b1;

  logic tr_a, tr_b, dg_a, dg_b, pr_a, pr_b, qv_a, qv_b, qi_a, qi_b;
  logic [CW-1:0] qx_a, qy_a, qx_b, qy_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int x;
    int y;
    bit inc;
    bit exc;
    int due;
  } exp_t;
  exp_t sb[$];

  point_in_triangle_pipe #(.COORD_W(CW), .INCLUSIVE(1'b1)) dut_a (
    .CLOCK_50(clk), .RESET_N(rst_n), .tri_load(tri_load),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .tri_ready(tr_a), .tri_degenerate(dg_a),
    .p_valid(p_valid), .p_ready(pr_a), .px(px), .py(py),
    .q_valid(qv_a), .q_ready(q_ready), .q_inside(qi_a), .q_px(qx_a), .q_py(qy_a)
  );

  point_in_triangle_pipe #(.COORD_W(CW), .INCLUSIVE(1'b0)) dut_b (
    .CLOCK_50(clk), .RESET_N(rst_n), .tri_load(tri_load),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .tri_ready(tr_b), .tri_degenerate(dg_b),
    .p_valid(p_valid), .p_ready(pr_b), .px(px), .py(py),
    .q_valid(qv_b), .q_ready(q_ready), .q_inside(qi_b), .q_px(qx_b), .q_py(qy_b)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input int x, input int y, input bit ei, input bit ee, input bit lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    p_valid = 1'b1;
    px = x[CW-1:0];
    py = y[CW-1:0];
    #1;
    while (!pr_a && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!pr_a) begin
      chk("p_ready_timeout", 0, 1);
      p_valid = 1'b0;
    end else begin
      e.x = x; e.y = y; e.inc = ei; e.exc = ee;
      e.due = lat ? cyc + pit_pkg::PIT_LATENCY : -1;
      sb.push_back(e);
    end
  endtask

  task automatic load_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input bit degen, input bit busy);
    int n;
    n = 0;
    @(negedge clk);
    p_valid = 1'b0;
    tri_load = 1'b1;
    ax = x0[CW-1:0]; ay = y0[CW-1:0];
    bx = x1[CW-1:0]; by = y1[CW-1:0];
    cx = x2[CW-1:0]; cy = y2[CW-1:0];
    #1;
    if (busy) begin
      chk("tri_ready_in_flight", tr_a, 0);
      chk("p_ready_during_load", pr_a, 0);
    end
    while (!tr_a && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!tr_a) chk("tri_ready_timeout", 0, 1);
    @(negedge clk);
    tri_load = 1'b0;
    @(negedge clk);
    #1;
    chk("tri_degenerate_inc", dg_a, degen);
    chk("tri_degenerate_exc", dg_b, degen);
    chk("p_ready_after_setup", pr_a, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    p_valid = 1'b0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: checks stability under stall and pops the scoreboard on each handshake.
  initial begin
    bit held;
    int snap;
    exp_t e;
    held = 1'b0;
    snap = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (qv_a || qv_b) chk("q_valid_inc_vs_exc", qv_b, qv_a);
        if (held) chk("q_stable_under_stall", int'({qv_a, qi_a, qi_b, qx_a, qy_a}), snap);
        if (qv_a && !q_ready) chk("p_ready_while_stalled", pr_a, 0);
        if (qv_a && q_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("q_inside_inclusive", qi_a, e.inc);
            chk("q_inside_exclusive", qi_b, e.exc);
            chk("q_px", qx_a, e.x);
            chk("q_py", qy_a, e.y);
            chk("q_px_exc", qx_b, e.x);
            if (e.due >= 0) chk("latency_cycle", cyc, e.due);
          end
        end
        held = qv_a && !q_ready;
        snap = int'({qv_a, qi_a, qi_b, qx_a, qy_a});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_q_valid", qv_a, 0);
    chk("reset_q_inside", qi_a, 0);
    chk("reset_q_px", qx_a, 0);
    chk("reset_tri_degenerate", dg_a, 0);
    chk("reset_p_ready", pr_a, 0);
    chk("reset_tri_ready", tr_a, 1);
    rst_n = 1'b1;

    // CCW right triangle: interior, outside, edge, vertex.
    load_tri(0, 0, 10, 0, 0, 10, 1'b0, 1'b0);
    send(2, 2, 1'b1, 1'b1, 1'b1);
    send(10, 10, 1'b0, 1'b0, 1'b1);
    send(5, 5, 1'b1, 1'b0, 1'b1);
    send(0, 0, 1'b1, 1'b0, 1'b1);
    drain();

    // Same triangle, clockwise winding.
    load_tri(0, 0, 0, 10, 10, 0, 1'b0, 1'b0);
    send(2, 2, 1'b1, 1'b1, 1'b1);
    send(10, 10, 1'b0, 1'b0, 1'b1);
    send(5, 5, 1'b1, 1'b0, 1'b1);
    send(0, 0, 1'b1, 1'b0, 1'b1);
    drain();

    // Collinear vertices: nothing is inside.
    load_tri(0, 0, 5, 5, 10, 10, 1'b1, 1'b0);
    send(5, 5, 1'b0, 1'b0, 1'b1);
    send(1, 1, 1'b0, 1'b0, 1'b1);
    drain();

    // 20-point raster with a 5-cycle output stall mid-stream.
    load_tri(0, 0, 10, 0, 0, 10, 1'b0, 1'b0);
    fork
      for (int i = 0; i < 20; i++) begin
        int x;
        int y;
        x = (i % 5) * 3;
        y = (i / 5) * 3;
        send(x, y, (x + y <= 10), (x > 0 && y > 0 && x + y < 10), 1'b0);
      end
      begin
        repeat (8) @(negedge clk);
        q_ready = 1'b0;
        repeat (5) @(negedge clk);
        q_ready = 1'b1;
      end
    join
    drain();

    // Two points in flight when the next triangle is requested.
    send(2, 2, 1'b1, 1'b1, 1'b1);
    send(10, 10, 1'b0, 1'b0, 1'b1);
    load_tri(0, 0, 2047, 0, 0, 2047, 1'b0, 1'b1);
    send(1023, 1024, 1'b1, 1'b0, 1'b1);
    send(1024, 1024, 1'b0, 1'b0, 1'b1);
    send(0, 2047, 1'b1, 1'b0, 1'b1);
    drain();

    // Reset in mid-stream drops everything in flight.
    send(100, 100, 1'b1, 1'b1, 1'b1);
    send(200, 200, 1'b1, 1'b1, 1'b1);
    send(300, 300, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    p_valid = 1'b0;
    #1;
    chk("q_valid_before_reset", qv_a, 1);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_q_valid_inc", qv_a, 0);
    chk("midreset_q_valid_exc", qv_b, 0);
    chk("midreset_p_ready", pr_a, 0);
    chk("midreset_tri_ready_idle", tr_b, 1);
    chk("midreset_tri_degenerate", dg_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_p_ready_idle", pr_a, 0);
    repeat (8) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
